tone_arbiter: RTL and testbench
===============================

# tone_arbiter

Shares the single `wave` square-wave generator between up to NREQ tone requesters, such as the song sequencer, a key-click source and an alarm. It uses round-robin arbitration. Each request carries a divider, a volume bit and a duration in tempo ticks. The arbiter latches the winning request, drives `wave` for that many ticks, then signals completion and inserts an optional silent articulation gap. It sits between the note sources and `wave`, and replaces direct `div`/`enable` driving.

## Interface
- `NREQ`, 3: number of requesters (2..8).
- `DIV_W`, 17: divider width, matching the note constants and `wave.div`.
- `DUR_W`, 8: duration width, in tempo ticks.
- `GAP_TICKS`, 1: silent ticks after each tone; 0 disables the gap.
- `clk`  in  1  system clock, 2.08 MHz.
- `rst_n`  in  1  asynchronous active-low reset.
- `tempo`  in  1  32 Hz square wave, asynchronous to `clk`.
- `req`  in  NREQ  level request per requester; held until `done` is seen.
- `req_div`  in  NREQ*DIV_W  divider of requester i at bits [i*DIV_W +: DIV_W].
- `req_dur`  in  NREQ*DUR_W  duration of requester i at bits [i*DUR_W +: DUR_W].
- `req_vol`  in  NREQ  volume bit per requester.
- `grant`  out  NREQ  one-hot, or all zero; high while requester i owns `wave`.
- `done`  out  NREQ  one-`clk` pulse when requester i's tone completes normally.
- `wave_div`  out  DIV_W  to `wave.div`.
- `wave_enable`  out  1  to `wave.enable`.
- `wave_volume`  out  1  to `wave.volume`.
- `busy`  out  1  high in PLAY or GAP.

## Operation
- Tempo input:
  - `tempo` passes through a 2-flop synchronizer and a rising-edge detector.
  - This produces `tick`, a one-`clk` pulse per tempo period.
- State IDLE:
  - If any `req` bit is set, pick the first set bit searching upward from `rr_ptr`, wrapping at NREQ.
  - Latch that requester's div, dur and vol.
  - Set `grant`.
  - Set `rr_ptr` to winner+1 mod NREQ.
  - If the latched dur ≠ 0, go to PLAY with `cnt`=dur.
  - If the latched dur = 0, pulse `done`, drop `grant` and return to IDLE. No sound is produced.
- State PLAY:
  - `wave_div` = latched div.
  - `wave_volume` = latched vol.
  - `wave_enable` = 1 when latched div ≠ 0; div=0 is a timed rest with enable low.
  - Each `tick` decrements `cnt`.
  - On the `tick` where `cnt`=1, pulse `done`, clear `grant` and go to GAP.
    - `cnt` is loaded with GAP_TICKS.
    - If GAP_TICKS=0, go to IDLE instead.
- Abort: if the granted `req` bit falls during PLAY, do the following on the next edge:
  - clear `grant`;
  - drive `wave_enable` low;
  - pulse no `done`;
  - go to GAP, or to IDLE if GAP_TICKS=0.
- State GAP: hold `wave_enable`=0 and `grant`=0. Each `tick` decrements `cnt`; at 0, go to IDLE.
- Latched fields are frozen while granted; changes on `req_div`/`req_dur`/`req_vol` are ignored until the next grant.
- Outside PLAY, `wave_div`=0, `wave_enable`=0 and `wave_volume`=0.

## Timing
- Reset: state IDLE, `rr_ptr`=0, `cnt`=0, synchronizer flops 0. All outputs are 0.
- Reset asserted mid-tone immediately silences `wave_enable`. No `done` is produced.
- All outputs are registered.
- A `req` seen high in IDLE at edge N gives `grant` and `wave_*` valid after edge N; latency is 1 clk.
- `tick` lags the `tempo` rising edge by 2–3 clk.
- Tick alignment:
  - A `tick` in the same cycle as the IDLE→PLAY transition is not counted.
  - The first counted tick may arrive anywhere in the following tempo period.
  - Tone length is therefore between dur-1 and dur tempo periods plus up to 1 period.
- Back-to-back tones:
  - After `done`, the earliest new `grant` is one clk after returning to IDLE.
  - With GAP_TICKS=0, `wave_enable` is low for exactly 1 clk between tones.
- `done` and `grant` falling occur on the same edge. Requesters must drop `req` within 1 clk of `done` to avoid being re-served.
  - A requester that does not drop `req` is re-granted only after the round-robin scan passes it.
- Arbitration ties are impossible: only one winner is chosen per IDLE cycle.

## Test plan
- Single request: `req`=001, div=M6 value, dur=4, vol=1, GAP=1.
  - Expect `grant`=001 one clk after `req`.
  - Expect `wave_enable`=1 for 4 counted ticks, then `done`[0] for one clk.
  - Expect 1 tick of silence, then IDLE.
- Round-robin: `req`=111 held throughout, each dur=1. Expect grants in the order 001, 010, 100, 001, each followed by a `done` on that bit.
- Rest and zero duration:
  - div=0, dur=2 gives `wave_enable`=0 throughout and `done` after 2 ticks.
  - dur=0 gives a `done` pulse one clk after `grant` with no PLAY.
- Abort: drop `req`[1] after 1 tick of a dur=8 tone. Expect `grant`=0 and `wave_enable`=0 on the next edge, no `done`[1], and GAP entered.
- Reset and async tempo:
  - Assert `rst_n`=0 mid-PLAY. Expect all outputs 0 immediately.
  - Drive `tempo` with random phase and jitter against `clk`. Expect exactly one `tick` per tempo rising edge.

Source files
------------

// File: rtl/tone_arbiter.sv
// Purpose: round-robin arbiter that shares one square-wave generator between NREQ tone requesters.
// Latency: a request seen in IDLE is granted and driving wave_* one clk later; all outputs are registered.
// Backpressure: requesters hold req until done; dropping req mid-tone aborts it, and nothing is served during PLAY or GAP.
module tone_arbiter #(
    parameter int NREQ      = 3,
    parameter int DIV_W     = 17,
    parameter int DUR_W     = 8,
    parameter int GAP_TICKS = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_tempo,
    input  logic [NREQ-1:0]        i_req,
    input  logic [NREQ*DIV_W-1:0]  i_req_div,
    input  logic [NREQ*DUR_W-1:0]  i_req_dur,
    input  logic [NREQ-1:0]        i_req_vol,
    output logic [NREQ-1:0]        o_grant,
    output logic [NREQ-1:0]        o_done,
    output logic [DIV_W-1:0]       o_wave_div,
    output logic                   o_wave_enable,
    output logic                   o_wave_volume,
    output logic                   o_busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [DUR_W-1:0] GAP_CNT = DUR_W'(GAP_TICKS);

    // S_ZERO holds the grant for one clk so a zero-length request still sees grant before done.
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_ZERO, S_GAP} state_t;
    localparam state_t S_AFTER = (GAP_TICKS == 0) ? S_IDLE : S_GAP;

    state_t              r_state, w_state_nxt;
    logic [PTR_W-1:0]    r_rr_ptr, w_rr_nxt;
    logic [PTR_W-1:0]    r_gidx, w_gidx_nxt;
    logic [DUR_W-1:0]    r_cnt, w_cnt_nxt;
    logic [DIV_W-1:0]    r_div, w_div_nxt;
    logic                r_vol, w_vol_nxt;
    logic [NREQ-1:0]     r_grant, w_grant_nxt;
    logic [NREQ-1:0]     r_done, w_done_nxt;
    logic [DIV_W-1:0]    r_wave_div;
    logic                r_wave_enable, r_wave_volume, r_busy;
    logic                r_tempo_s1, r_tempo_s2, r_tempo_s3;
    logic                w_tick;
    logic                w_found;
    logic [PTR_W-1:0]    w_win, w_win_next_ptr;
    logic [PTR_W:0]      w_sum;
    logic [DUR_W-1:0]    w_win_dur;

    // Two-flop synchronizer for the asynchronous tempo input plus one flop for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tempo_s1 <= 1'b0;
            r_tempo_s2 <= 1'b0;
            r_tempo_s3 <= 1'b0;
        end else begin
            r_tempo_s1 <= i_tempo;
            r_tempo_s2 <= r_tempo_s1;
            r_tempo_s3 <= r_tempo_s2;
        end
    end

    assign w_tick = r_tempo_s2 & ~r_tempo_s3;

    // Round-robin scan: first set req bit at or above rr_ptr, wrapping at NREQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(i);
            if (w_sum >= (PTR_W+1)'(NREQ)) begin
                w_sum = w_sum - (PTR_W+1)'(NREQ);
            end
            if (!w_found && i_req[w_sum[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[PTR_W-1:0];
            end
        end
        w_win_next_ptr = (w_win == PTR_W'(NREQ - 1)) ? '0 : w_win + PTR_W'(1);
        w_win_dur      = i_req_dur[w_win*DUR_W +: DUR_W];
    end

    // Next-state logic; output values are derived from the next state so they can be registered.
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_gidx_nxt  = r_gidx;
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_div;
        w_vol_nxt   = r_vol;
        w_grant_nxt = r_grant;
        w_done_nxt  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_div_nxt   = i_req_div[w_win*DIV_W +: DIV_W];
                    w_vol_nxt   = i_req_vol[w_win];
                    w_gidx_nxt  = w_win;
                    w_rr_nxt    = w_win_next_ptr;
                    w_grant_nxt = NREQ'(1) << w_win;
                    if (w_win_dur != '0) begin
                        w_state_nxt = S_PLAY;
                        w_cnt_nxt   = w_win_dur;
                    end else begin
                        w_state_nxt = S_ZERO;
                    end
                end
            end
            S_ZERO: begin
                w_done_nxt  = r_grant;
                w_grant_nxt = '0;
                w_state_nxt = S_IDLE;
            end
            S_PLAY: begin
                // Abort wins over a coinciding final tick: a withdrawn request gets no done.
                if (!i_req[r_gidx]) begin
                    w_grant_nxt = '0;
                    w_cnt_nxt   = GAP_CNT;
                    w_state_nxt = S_AFTER;
                end else if (w_tick) begin
                    if (r_cnt == DUR_W'(1)) begin
                        w_done_nxt  = r_grant;
                        w_grant_nxt = '0;
                        w_cnt_nxt   = GAP_CNT;
                        w_state_nxt = S_AFTER;
                    end else begin
                        w_cnt_nxt = r_cnt - DUR_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tick) begin
                    w_cnt_nxt = r_cnt - DUR_W'(1);
                    if (r_cnt == DUR_W'(1)) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State, latched request fields and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_gidx        <= '0;
            r_cnt         <= '0;
            r_div         <= '0;
            r_vol         <= 1'b0;
            r_grant       <= '0;
            r_done        <= '0;
            r_wave_div    <= '0;
            r_wave_enable <= 1'b0;
            r_wave_volume <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rr_ptr      <= w_rr_nxt;
            r_gidx        <= w_gidx_nxt;
            r_cnt         <= w_cnt_nxt;
            r_div         <= w_div_nxt;
            r_vol         <= w_vol_nxt;
            r_grant       <= w_grant_nxt;
            r_done        <= w_done_nxt;
            r_wave_div    <= (w_state_nxt == S_PLAY) ? w_div_nxt : '0;
            r_wave_enable <= (w_state_nxt == S_PLAY) && (w_div_nxt != '0);
            r_wave_volume <= (w_state_nxt == S_PLAY) && w_vol_nxt;
            r_busy        <= (w_state_nxt == S_PLAY) || (w_state_nxt == S_GAP);
        end
    end

    assign o_grant       = r_grant;
    assign o_done        = r_done;
    assign o_wave_div    = r_wave_div;
    assign o_wave_enable = r_wave_enable;
    assign o_wave_volume = r_wave_volume;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_tone_arbiter.sv
// Bench for tone_arbiter: directed requests against a jittered free-running tempo.
// Expected tones are queued at issue; a negedge monitor rebuilds each tone and compares.
`timescale 1ns/1ps
module tb_tone_arbiter;

    localparam int NREQ  = 3;
    localparam int DIV_W = 17;
    localparam int DUR_W = 8;
    localparam logic [16:0] M6 = 17'd2985;   // M6 note divider

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  tempo = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*DIV_W-1:0] req_div = '0;
    logic [NREQ*DUR_W-1:0] req_dur = '0;
    logic [NREQ-1:0]       req_vol = '0;
    logic [NREQ-1:0]       grant, done;
    logic [DIV_W-1:0]      wave_div;
    logic                  wave_enable, wave_volume, busy;

    tone_arbiter #(.NREQ(NREQ), .DIV_W(DIV_W), .DUR_W(DUR_W), .GAP_TICKS(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_tempo(tempo),
        .i_req(req), .i_req_div(req_div), .i_req_dur(req_dur), .i_req_vol(req_vol),
        .o_grant(grant), .o_done(done), .o_wave_div(wave_div),
        .o_wave_enable(wave_enable), .o_wave_volume(wave_volume), .o_busy(busy)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int tempo_rises = 0;

    typedef struct {
        logic [2:0]  gnt;
        logic [2:0]  done;
        int          ticks;
        int          mode;     // 0 enable always low, 1 always high, 2 mixed
        logic [16:0] div;
        logic        vol;
        logic        stable;
    } rec_t;

    rec_t exp_q[$];
    rec_t got, want;

    // Free-running tempo with random phase and per-edge jitter, asynchronous to clk.
    initial begin
        #($urandom_range(1, 150) * 1.0 + 0.37);
        forever begin
            tempo = 1'b1;
            tempo_rises++;
            #(97.0 + $urandom_range(0, 60) / 10.0);
            tempo = 1'b0;
            #(97.0 + $urandom_range(0, 60) / 10.0);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_tone(input logic [2:0] g, input logic [2:0] d, input int t,
                               input int m, input logic [16:0] dv, input logic v);
        rec_t r;
        r.gnt = g; r.done = d; r.ticks = t; r.mode = m; r.div = dv; r.vol = v; r.stable = 1'b1;
        exp_q.push_back(r);
    endtask

    task automatic set_req(input int idx, input logic [16:0] dv, input logic [7:0] dur, input logic v);
        req_div[idx*DIV_W +: DIV_W] = dv;
        req_dur[idx*DUR_W +: DUR_W] = dur;
        req_vol[idx] = v;
    endtask

    // Returns at a negedge n clk after the next tempo rise, clear of any tick.
    task automatic after_rise(input int n);
        @(posedge tempo);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done(input int idx, input string name, output int cyc);
        cyc = 0;
        @(negedge clk);
        cyc = 1;
        while (done[idx] !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk(name, int'(done[idx]), 1);
    endtask

    // Monitor: tracks each grant window and compares it with the next queued expectation.
    logic        in_tone = 1'b0;
    logic [2:0]  cur_gnt;
    int          t0, n_hi, n_lo;
    logic [16:0] cur_div;
    logic        cur_vol, cur_stable;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_tone = 1'b0;
        end else begin
            if (in_tone && grant != cur_gnt) begin
                got.gnt = cur_gnt; got.done = done; got.ticks = tempo_rises - t0;
                got.mode = (n_hi == 0) ? 0 : ((n_lo == 0) ? 1 : 2);
                got.div = cur_div; got.vol = cur_vol; got.stable = cur_stable;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_tone: grant %b, expected no tone", cur_gnt);
                end else begin
                    want = exp_q.pop_front();
                    chk("tone_grant",  int'(got.gnt),    int'(want.gnt));
                    chk("tone_done",   int'(got.done),   int'(want.done));
                    chk("tone_ticks",  got.ticks,        want.ticks);
                    chk("tone_enable", got.mode,         want.mode);
                    chk("tone_div",    int'(got.div),    int'(want.div));
                    chk("tone_vol",    int'(got.vol),    int'(want.vol));
                    chk("tone_stable", int'(got.stable), int'(want.stable));
                end
                in_tone = 1'b0;
            end else if (done != '0) begin
                compared++;
                mismatched++;
                $display("FAIL stray_done: got %b, expected 000", done);
            end
            if (!in_tone && grant != '0) begin
                in_tone = 1'b1; cur_gnt = grant; t0 = tempo_rises;
                n_hi = 0; n_lo = 0; cur_div = wave_div; cur_vol = wave_volume; cur_stable = 1'b1;
            end
            if (in_tone) begin
                if (wave_enable) n_hi++; else n_lo++;
                if (wave_div != cur_div) cur_stable = 1'b0;
            end
        end
    end

    initial begin
        int n, k, cyc;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_grant", int'(grant), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_div", int'(wave_div), 0);
        chk("rst_enable", int'(wave_enable), 0);
        chk("rst_volume", int'(wave_volume), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;

        // Round-robin from rr_ptr=0 with all three held
        set_req(0, 17'd1000, 8'd1, 1'b1);
        set_req(1, 17'd2000, 8'd1, 1'b0);
        set_req(2, 17'd3000, 8'd1, 1'b1);
        expect_tone(3'b001, 3'b001, 1, 1, 17'd1000, 1'b1);
        expect_tone(3'b010, 3'b010, 1, 1, 17'd2000, 1'b0);
        expect_tone(3'b100, 3'b100, 1, 1, 17'd3000, 1'b1);
        expect_tone(3'b001, 3'b001, 1, 1, 17'd1000, 1'b1);
        after_rise(5);
        req = 3'b111;
        n = 0;
        k = 0;
        while (n < 4 && k < 5000) begin
            @(negedge clk);
            k++;
            if (done != '0) n++;
        end
        req = '0;
        chk("rr_done_count", n, 4);
        after_rise(5);

        // Single tone with latched fields frozen against input changes
        set_req(0, M6, 8'd4, 1'b1);
        expect_tone(3'b001, 3'b001, 4, 1, M6, 1'b1);
        after_rise(5);
        req = 3'b001;
        @(negedge clk);
        chk("single_grant_lat", int'(grant), 1);
        chk("single_busy", int'(busy), 1);
        set_req(0, 17'h1FFFF, 8'd9, 1'b0);
        wait_done(0, "single_done", cyc);
        req = '0;
        chk("single_gap_busy", int'(busy), 1);
        chk("single_gap_enable", int'(wave_enable), 0);
        @(posedge tempo);
        @(posedge clk);
        @(negedge clk);
        chk("gap_before_tick", int'(busy), 1);
        repeat (4) @(negedge clk);
        chk("gap_after_tick", int'(busy), 0);

        // Timed rest: div=0
        set_req(2, 17'd0, 8'd2, 1'b1);
        expect_tone(3'b100, 3'b100, 2, 0, 17'd0, 1'b1);
        after_rise(5);
        req = 3'b100;
        wait_done(2, "rest_done", cyc);
        req = '0;
        after_rise(5);

        // Zero duration: done one clk after grant, never PLAY
        set_req(1, 17'd5000, 8'd0, 1'b1);
        expect_tone(3'b010, 3'b010, 0, 0, 17'd0, 1'b0);
        after_rise(5);
        req = 3'b010;
        @(negedge clk);
        chk("zero_grant", int'(grant), 2);
        chk("zero_busy", int'(busy), 0);
        wait_done(1, "zero_done", cyc);
        req = '0;
        chk("zero_done_lat", cyc, 1);
        @(negedge clk);
        chk("zero_no_regrant", int'(grant), 0);

        // Abort after one tick of a dur=8 tone
        set_req(1, 17'd4321, 8'd8, 1'b0);
        expect_tone(3'b010, 3'b000, 1, 1, 17'd4321, 1'b0);
        after_rise(5);
        req = 3'b010;
        after_rise(5);
        req = '0;
        @(negedge clk);
        chk("abort_grant", int'(grant), 0);
        chk("abort_enable", int'(wave_enable), 0);
        chk("abort_busy_gap", int'(busy), 1);
        after_rise(5);
        chk("abort_gap_end", int'(busy), 0);

        // Reset asserted mid-PLAY silences at once
        set_req(0, 17'd777, 8'd8, 1'b1);
        after_rise(5);
        req = 3'b001;
        @(posedge tempo);
        after_rise(5);
        chk("pre_rst_enable", int'(wave_enable), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_grant", int'(grant), 0);
        chk("midrst_enable", int'(wave_enable), 0);
        chk("midrst_div", int'(wave_div), 0);
        chk("midrst_volume", int'(wave_volume), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_grant", int'(grant), 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
